// File: rtl/cons_cell_store_pkg.sv
// Shared constants for the cons-cell heap: default widths, the NIL pointer and FSM state codes.
// The optional pointer bounds check is enabled by defining CONS_CELL_BOUNDS_CHECK_EN.
package cons_cell_store_pkg;

  localparam int DEFAULT_DATA_W = 24;
  localparam int DEFAULT_ADDR_W = 10;
  localparam int NIL_PTR        = 0;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_CONS_B = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // True when two or more request lines are high together.
  function automatic logic multi_req(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cons_cell_store_cell_ram.sv
// Single-port cell RAM: one word holds {car, cdr}; write-enable and registered read.
// No reset on the array so it maps onto block RAM.
module cons_cell_store_cell_ram #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 48
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cons_cell_store.sv
// Cons-cell heap responder: car/cdr lookups and bump-allocated cons, two-cycle request/response.
// Define CONS_CELL_BOUNDS_CHECK_EN to add the pointer bounds check and the bad_ptr output.
module cons_cell_store
  import cons_cell_store_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              get_car,
  input  logic              get_cdr,
  input  logic              get_cons,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              is_ready,
  output logic              heap_full,
  output logic              proto_err,
`ifdef CONS_CELL_BOUNDS_CHECK_EN
  output logic              bad_ptr,
`endif
  output state_t            dbg_state_o,
  output logic [ADDR_W-1:0] dbg_free_ptr_o
);

  // Handshake: is_ready high means the block is in IDLE or RESP and samples the request
  // lines on the next rising edge; data_out is valid whenever is_ready is high after a
  // response and holds until the next one. Requests seen while is_ready is low are dropped.

  state_t              state_q, state_d;
  logic                sel_cdr_q, sel_cdr_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [ADDR_W-1:0]   free_ptr_q, free_ptr_d;
  logic                heap_full_q, heap_full_d;
  logic                proto_err_q, proto_err_d;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
  logic                bad_ptr_q, bad_ptr_d;
  logic                oob;
`endif

  logic                  accepting;
  logic                  req_any;
  logic [ADDR_W-1:0]     req_ptr;
  logic                  req_nil;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_W-1:0]     ram_addr;
  logic [2*DATA_W-1:0]   ram_wdata;
  logic [2*DATA_W-1:0]   ram_rdata;

  assign accepting = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign req_any   = get_car | get_cdr | get_cons;
  assign req_ptr   = data_in[ADDR_W-1:0];
  assign req_nil   = (req_ptr == ADDR_W'(NIL_PTR));

`ifdef CONS_CELL_BOUNDS_CHECK_EN
  // Once the heap is full every non-NIL pointer names an allocated cell.
  assign oob = !req_nil && !heap_full_q && (req_ptr >= free_ptr_q);
`endif

  always_comb begin
    state_d     = state_q;
    sel_cdr_d   = sel_cdr_q;
    zero_d      = zero_q;
    opnd_d      = opnd_q;
    data_out_d  = data_out_q;
    free_ptr_d  = free_ptr_q;
    heap_full_d = heap_full_q;
    proto_err_d = proto_err_q;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
    bad_ptr_d   = bad_ptr_q;
`endif
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = req_ptr;
    ram_wdata   = {opnd_q, data_in};

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (req_any) begin
          opnd_d = data_in;
          if (multi_req(get_car, get_cdr, get_cons)) begin
            proto_err_d = 1'b1;
          end
          if (get_car || get_cdr) begin
            state_d   = ST_READ;
            sel_cdr_d = !get_car;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
            zero_d = req_nil || oob;
            if (oob) begin
              bad_ptr_d = 1'b1;
            end
`else
            zero_d = req_nil;
`endif
            ram_re = !zero_d;
          end else begin
            state_d = ST_CONS_B;
          end
        end
      end
      ST_READ: begin
        state_d = ST_RESP;
        if (zero_q) begin
          data_out_d = '0;
        end else if (sel_cdr_q) begin
          data_out_d = ram_rdata[DATA_W-1:0];
        end else begin
          data_out_d = ram_rdata[2*DATA_W-1:DATA_W];
        end
      end
      ST_CONS_B: begin
        state_d = ST_RESP;
        if (heap_full_q) begin
          data_out_d = '0;
        end else begin
          // A reset landing on this edge discards the cons, including its write.
          ram_we     = !rst;
          ram_addr   = free_ptr_q;
          data_out_d = {{(DATA_W-ADDR_W){1'b0}}, free_ptr_q};
          if (free_ptr_q == {ADDR_W{1'b1}}) begin
            heap_full_d = 1'b1;
          end else begin
            free_ptr_d = free_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_cdr_q   <= 1'b0;
      zero_q      <= 1'b0;
      opnd_q      <= '0;
      data_out_q  <= '0;
      free_ptr_q  <= {{(ADDR_W-1){1'b0}}, 1'b1};
      heap_full_q <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
      bad_ptr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_cdr_q   <= sel_cdr_d;
      zero_q      <= zero_d;
      opnd_q      <= opnd_d;
      data_out_q  <= data_out_d;
      free_ptr_q  <= free_ptr_d;
      heap_full_q <= heap_full_d;
      proto_err_q <= proto_err_d;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
      bad_ptr_q   <= bad_ptr_d;
`endif
    end
  end

  cons_cell_store_cell_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (2*DATA_W)
  ) u_cell_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign data_out       = data_out_q;
  assign is_ready       = accepting;
  assign heap_full      = heap_full_q;
  assign proto_err      = proto_err_q;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
  assign bad_ptr        = bad_ptr_q;
`endif
  assign dbg_state_o    = state_q;
  assign dbg_free_ptr_o = free_ptr_q;

endmodule

// File: tb/tb_cons_cell_store.sv
// Directed bench for cons_cell_store: a default-size heap (index 0) and a 4-cell heap (index 1).
// Responses are predicted from a small heap model and checked from an expected queue.
module tb_cons_cell_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        car_r [2];
  logic        cdr_r [2];
  logic        cons_r[2];
  logic [23:0] din   [2];
  logic [23:0] dout  [2];
  logic        rdy   [2];
  logic        full  [2];
  logic        perr  [2];
  logic [1:0]  st    [2];
  logic [9:0]  fp_w;
  logic [1:0]  fp_n;
`ifdef CONS_CELL_BOUNDS_CHECK_EN
  logic        bp    [2];
`endif

  logic [23:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [23:0] car_m[int];
  logic [23:0] cdr_m[int];
  int          next_m[2];
  bit          full_m[2];

  cons_cell_store dut_w (
    .clk(clk), .rst(rst), .get_car(car_r[0]), .get_cdr(cdr_r[0]), .get_cons(cons_r[0]),
    .data_in(din[0]), .data_out(dout[0]), .is_ready(rdy[0]), .heap_full(full[0]),
    .proto_err(perr[0]),
`ifdef CONS_CELL_BOUNDS_CHECK_EN
    .bad_ptr(bp[0]),
`endif
    .dbg_state_o(st[0]), .dbg_free_ptr_o(fp_w)
  );

  cons_cell_store #(.DATA_W(24), .ADDR_W(2)) dut_n (
    .clk(clk), .rst(rst), .get_car(car_r[1]), .get_cdr(cdr_r[1]), .get_cons(cons_r[1]),
    .data_in(din[1]), .data_out(dout[1]), .is_ready(rdy[1]), .heap_full(full[1]),
    .proto_err(perr[1]),
`ifdef CONS_CELL_BOUNDS_CHECK_EN
    .bad_ptr(bp[1]),
`endif
    .dbg_state_o(st[1]), .dbg_free_ptr_o(fp_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] free_ptr_of(input int u);
    return (u == 0) ? {22'd0, fp_w} : {30'd0, fp_n};
  endfunction

  function automatic int max_ptr(input int u);
    return (u == 0) ? 1023 : 3;
  endfunction

  task automatic drive(input int u, input logic c, input logic d, input logic k,
                       input logic [23:0] v);
    car_r[u]  = c;
    cdr_r[u]  = d;
    cons_r[u] = k;
    din[u]    = v;
  endtask

  // One request: sampled at the next edge, busy for one cycle, response after the second edge.
  task automatic op(input int u, input logic c, input logic d, input logic k,
                    input logic [23:0] v, input logic [23:0] v2, input logic poke,
                    input logic [23:0] expv, input string tag);
    @(negedge clk);
    drive(u, c, d, k, v);
    exp_q.push_back(expv);
    @(posedge clk); #1;
    check({tag, "_busy"}, {31'd0, rdy[u]}, 32'd0);
    @(negedge clk);
    drive(u, 1'b0, poke, poke, v2);
    @(posedge clk); #1;
    check({tag, "_ready"}, {31'd0, rdy[u]}, 32'd1);
    check({tag, "_data"}, {8'd0, dout[u]}, {8'd0, exp_q.pop_front()});
  endtask

  task automatic idle_chk(input int u, input string tag);
    @(negedge clk);
    drive(u, 1'b0, 1'b0, 1'b0, 24'd0);
    @(posedge clk); #1;
    check({tag, "_idle_state"}, {30'd0, st[u]}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, rdy[u]}, 32'd1);
  endtask

  task automatic cons(input int u, input logic [23:0] car_v, input logic [23:0] cdr_v,
                      input string tag);
    logic [23:0] expv;
    if (full_m[u]) begin
      expv = 24'd0;
    end else begin
      expv = 24'(next_m[u]);
      car_m[u*4096 + next_m[u]] = car_v;
      cdr_m[u*4096 + next_m[u]] = cdr_v;
      if (next_m[u] == max_ptr(u)) full_m[u] = 1'b1;
      else next_m[u]++;
    end
    op(u, 1'b0, 1'b0, 1'b1, car_v, cdr_v, 1'b0, expv, tag);
    check({tag, "_full"}, {31'd0, full[u]}, {31'd0, full_m[u]});
    check({tag, "_free_ptr"}, free_ptr_of(u), 32'(next_m[u]));
  endtask

  task automatic rd(input int u, input logic sel_cdr, input logic [23:0] w, input string tag);
    int          p;
    logic [23:0] expv;
    p = (u == 0) ? int'(w[9:0]) : int'(w[1:0]);
    if (p == 0) expv = 24'd0;
    else if (sel_cdr) expv = cdr_m[u*4096 + p];
    else expv = car_m[u*4096 + p];
    op(u, !sel_cdr, sel_cdr, 1'b0, w, 24'($urandom), 1'b0, expv, tag);
  endtask

  task automatic model_reset();
    car_m.delete();
    cdr_m.delete();
    for (int i = 0; i < 2; i++) begin
      next_m[i] = 1;
      full_m[i] = 1'b0;
    end
  endtask

  initial begin
    logic [23:0] w;
    int          p;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 1'b0, 24'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_data_out", {8'd0, dout[i]}, 32'd0);
      check("rst_ready", {31'd0, rdy[i]}, 32'd1);
      check("rst_heap_full", {31'd0, full[i]}, 32'd0);
      check("rst_proto_err", {31'd0, perr[i]}, 32'd0);
      check("rst_state", {30'd0, st[i]}, 32'd0);
      check("rst_free_ptr", free_ptr_of(i), 32'd1);
`ifdef CONS_CELL_BOUNDS_CHECK_EN
      check("rst_bad_ptr", {31'd0, bp[i]}, 32'd0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;

    // NIL on a fresh heap: cell 0 was never written, so any RAM dependence shows as X.
    rd(0, 1'b0, 24'h000000, "nil_fresh");
    cons(0, 24'h000005, 24'h000000, "cons1");
    rd(0, 1'b0, 24'h000001, "car1");
    rd(0, 1'b1, 24'hAB0001, "cdr_tag");
    cons(0, 24'hABCDEF, 24'h123456, "cons2");
    rd(0, 1'b0, 24'hFF0002, "car2_tag");
    rd(0, 1'b1, 24'h000002, "cdr2");
    for (int i = 0; i < 4; i++) cons(0, 24'($urandom), 24'($urandom), "cons_rand");
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(next_m[0] - 1, 1);
      w = {8'($urandom), 6'd0, 10'(p)};
      rd(0, 1'($urandom_range(1, 0)), w, "rd_rand");
    end
    rd(0, 1'b1, 24'h5A0000, "nil_tag");
    idle_chk(0, "seq_a");
    check("perr_before", {31'd0, perr[0]}, 32'd0);

    // car+cons together: car wins, no allocation; a busy-cycle cdr/cons pulse is dropped.
    op(0, 1'b1, 1'b0, 1'b1, 24'h000001, 24'h000002, 1'b1, car_m[1], "multi");
    idle_chk(0, "multi");
    check("multi_proto_err", {31'd0, perr[0]}, 32'd1);
    check("multi_free_ptr", free_ptr_of(0), 32'(next_m[0]));

    for (int i = 1; i <= 3; i++) cons(1, 24'h000100 + 24'(i), 24'h000200 + 24'(i), "n_cons");
    cons(1, 24'hEEEEEE, 24'hDDDDDD, "n_cons_full");
    idle_chk(1, "seq_n");
    for (int i = 1; i <= 3; i++) begin
      rd(1, 1'b0, 24'(i), "n_car");
      rd(1, 1'b1, 24'h110000 + 24'(i), "n_cdr");
    end
    idle_chk(1, "seq_n2");

    // Reset while waiting for the cdr operand of a cons.
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b1, 24'h777777);
    @(posedge clk); #1;
    check("rstc_busy", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 24'h888888);
    @(posedge clk); #1;
    check("rstc_ready", {31'd0, rdy[0]}, 32'd1);
    check("rstc_free_ptr", free_ptr_of(0), 32'd1);
    check("rstc_data_out", {8'd0, dout[0]}, 32'd0);
    check("rstc_state", {30'd0, st[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

`ifdef CONS_CELL_BOUNDS_CHECK_EN
    op(0, 1'b1, 1'b0, 1'b0, 24'h000005, 24'd0, 1'b0, 24'd0, "bounds");
    check("bounds_bad_ptr", {31'd0, bp[0]}, 32'd1);
`endif
    cons(0, 24'h00AAAA, 24'h00BBBB, "cons_post");
    rd(0, 1'b0, 24'h000001, "car_post");
    rd(0, 1'b1, 24'h000001, "cdr_post");
    idle_chk(0, "end");
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cons_cell_store.md
# cons_cell_store

Cons-cell heap responder for the Lisp machine datapath: services the one-cycle `get_car` / `get_cdr` / `get_cons` request pulses issued by the machine controller and answers on `data_out` with an `is_ready` handshake. It holds two parallel cell arrays (car half, cdr half) and a bump allocator for new cells. Pointer 0 is NIL. It sits directly between the top-level sequencer and on-chip block RAM.

## Interface
- `DATA_W`, 24: word width of `data_in` / `data_out` and of each cell half.
- `ADDR_W`, 10: pointer field width (low `ADDR_W` bits of a word); heap depth 2^ADDR_W cells, cell 0 reserved as NIL.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: **synchronous, active-high** reset.
- `get_car` input 1: read car half of cell addressed by `data_in[ADDR_W-1:0]`.
- `get_cdr` input 1: read cdr half of cell addressed by `data_in[ADDR_W-1:0]`.
- `get_cons` input 1: allocate cell; `data_in` = car operand this cycle, cdr operand next cycle.
- `data_in` input DATA_W: pointer or operand.
- `data_out` output DATA_W: response word, held until next response.
- `is_ready` output 1: high = idle and accepting; response valid in the cycle it rises.
- `heap_full` output 1: sticky, set when last cell (2^ADDR_W−1) allocated.
- `proto_err` output 1: sticky, set on more than one request line high in an accepted cycle.

## Operation
- States: IDLE, READ, CONS_B, RESP.
- IDLE (`is_ready`=1): on an edge with any request high, capture `data_in`, leave IDLE; requests while `is_ready`=0 are ignored, not queued.
- Multiple requests in one accepted cycle: priority car > cdr > cons, set `proto_err`.
- car/cdr: IDLE → READ (RAM read issued) → RESP (`data_out` = selected half, `is_ready`=1) → IDLE next edge unless a new request is sampled in RESP (RESP accepts like IDLE).
- Pointer 0 in car/cdr: response 0, RAM not consulted for result.
- cons: IDLE → CONS_B; at CONS_B edge sample `data_in` as cdr, write car+cdr to cell `free_ptr` → RESP with `data_out` = {zeros, `free_ptr`}; `free_ptr` increments.
- cons with `heap_full`=1: no write, response 0, `free_ptr` unchanged.
- Allocator: `free_ptr` resets to 1; allocating cell 2^ADDR_W−1 sets `heap_full`; `free_ptr` never wraps to 0.
- Upper `DATA_W−ADDR_W` bits of pointers (tag bits) ignored on lookup; operand words stored full width.
- Reset mid-operation: state → IDLE, pending op discarded; a cons write already committed at CONS_B edge stays.

## Timing
- Reset values: `data_out`=0, `is_ready`=1, `heap_full`=0, `proto_err`=0, `free_ptr`=1, state IDLE.
- Request sampled at edge T → `is_ready`=0 after T → response and `is_ready`=1 after edge T+2. Latency 2 cycles, all ops.
- cons cdr operand must be on `data_in` for edge T+1; request lines ignored at that edge.
- Back-to-back: new request may be sampled at edge T+2 (the edge leaving RESP-entry), i.e. one op per 2 cycles sustained.
- RAM: synchronous read, one-cycle latency; write and read never in same cycle.

## Configuration
- `CONS_CELL_BOUNDS_CHECK_EN` defined: car/cdr with pointer ≥ `free_ptr` returns 0 and sets sticky output `bad_ptr` (port exists only in this build, reset 0).
- Undefined: no compare logic, no `bad_ptr` port; out-of-range nonzero pointer returns raw RAM contents (undefined for never-written cells). NIL handling identical in both builds.

## Structure
- Shared header `cons_cell.vh`: `DATA_W`/`ADDR_W` defaults, NIL constant, state encodings, pointer-field slice macro; included by this block and the sequencer.
- Sub-module `cell_ram`: single-port synchronous RAM, 2^ADDR_W × 2·DATA_W, write-enable, registered read; FSM and allocator stay in `cons_cell_store`.

## Test plan
- Reset then `get_cons` with car=24'h000005, next cycle cdr=24'h000000 → after 2 cycles `data_out`=24'h000001, `is_ready`=1.
- Then `get_car` data_in=24'h000001 → 24'h000005 after 2 cycles; `get_cdr` data_in=24'hAB0001 (tag set) → 24'h000000.
- `get_car` data_in=0 → `data_out`=0 at latency 2; no RAM dependence.
- ADDR_W=2: three cons → pointers 1,2,3, `heap_full`=1 after third; fourth cons → 0, cell contents unchanged.
- `get_car`+`get_cons` same cycle → car executed, `proto_err`=1; pulse `get_cdr` while `is_ready`=0 → ignored.
- Assert `rst` at CONS_B cycle → next cycle `is_ready`=1, `free_ptr`=1, `data_out`=0; with `CONS_CELL_BOUNDS_CHECK_EN`, `get_car` pointer 5 on empty heap → 0, `bad_ptr`=1.
